wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
- Write-back trace capture that sits directly downstream of the WB stage.
- Observes every architectural register write leaving MEMWB/WB (destination, data, PC) and queues it in a FIFO.
- Presents one entry at a time to the 8-digit seven-segment display path, so register writes can be stepped through at human speed while the core runs on the divided clock.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- PTR_W, 4, pointer width; equals log2(DEPTH).
- DROP_W, 8, width of the saturating dropped-write counter.

Ports:
- Clock  in  1  core clock (the divided clock that drives the pipeline).
- Reset  in  1  synchronous, active-low reset.
- Freeze  in  1  when 1, no new writes are captured; readout continues.
- WB_RegWrite  in  1  register-file write enable from MEMWB.
- WB_RegDest  in  5  destination register from MEMWB.
- WB_WriteData  in  32  write-back data (WB mux output).
- WB_PC  in  32  PC of the writing instruction from MEMWB.
- Advance  in  1  single-cycle pulse (debounced button or slow tick) that requests the next entry.
- Disp_Data  out  32  data of the displayed entry.
- Disp_PC  out  32  PC of the displayed entry.
- Disp_RegDest  out  5  register of the displayed entry.
- Disp_Valid  out  1  1 once any entry has been shown since reset.
- Count  out  PTR_W+1  current FIFO occupancy, 0..DEPTH.
- Overflow  out  1  sticky; a write was dropped because the FIFO was full.
- Dropped  out  DROP_W  saturating count of dropped writes.

Behaviour:
- Reset (Reset==0 sampled at a Clock rising edge), taking priority over everything:
  - Pointers = 0, Count = 0.
  - Disp_Data = 0, Disp_PC = 0, Disp_RegDest = 0, Disp_Valid = 0.
  - Overflow = 0, Dropped = 0.
  - FIFO storage contents don't-care.
- Capture qualifier: cap = WB_RegWrite & (WB_RegDest != 0) & ~Freeze.
  - Writes to $0 are never captured.
  - Entry = {WB_RegDest, WB_PC, WB_WriteData}, 69 bits.
- Push: when cap and either Count < DEPTH or a pop occurs in the same cycle.
  - The entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Drop: when cap, Count == DEPTH and no pop that cycle.
  - Overflow is set to 1 and stays set until reset.
  - Dropped increments and saturates at 2^DROP_W-1.
- Pop: when Advance and Count != 0.
  - Entry at rd_ptr loads into the Disp_* registers on the same edge; visible 1 cycle after Advance.
  - Disp_Valid is set to 1; rd_ptr increments modulo DEPTH.
- Advance with Count == 0 is ignored; Disp_* and Disp_Valid hold.
- There is no bypass: push and Advance in the same cycle with Count == 0 stores the entry, Count becomes 1, and the display is unchanged.
- Simultaneous push and pop: Count unchanged, pointers both advance, no drop, even at Count == DEPTH.
- Count update: Count += push - pop each cycle; the full/empty distinction comes from Count, not pointer equality.
- Advance held high for multiple cycles pops one entry per cycle. The upstream debouncer is responsible for pulse shaping.
- Freeze does not affect pop, Overflow, or Dropped; writes suppressed by Freeze are not counted as dropped.
- Reset asserted mid-stream discards all queued entries. First capture after reset release goes to slot 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then three writes (r8=0x11 @PC 0x00, r9=0x22 @0x04, r0=0x33 @0x08) -> Count=2 (r0 ignored). Advance -> next cycle Disp_RegDest=8, Disp_Data=0x11, Disp_PC=0x00, Disp_Valid=1, Count=1.
- Fill with 16 writes (r1..r16, data=i), then 3 more writes -> Count=16, Overflow=1, Dropped=3. Drain 16 Advances -> data sequence 1..16 in order, Count=0; a 17th Advance leaves Disp_Data=16.
- At Count=16, pulse cap and Advance together -> Count stays 16, Dropped unchanged. The displayed entry is the oldest, and the new entry appears last after full drain (pointer wrap verified).
- Empty FIFO, push and Advance in the same cycle -> Count=1, Disp_Valid remains 0. Next Advance shows the entry.
- Freeze=1 during 5 writes -> Count=0, Dropped=0. Freeze=0 then 1 write -> Count=1.
- Force 260 drops -> Dropped=255 saturated. Assert Reset low for 1 cycle mid-stream -> all outputs 0 next cycle; the subsequent write/Advance returns that write.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
// Bundles the write-back capture side and the display side of the trace buffer.
// The master drives the capture/advance inputs; the slave is the buffer itself.
interface wb_trace_buffer_if #(
  parameter int PTR_W  = 4,
  parameter int DROP_W = 8
);
  logic              Freeze;
  logic              WB_RegWrite;
  logic [4:0]        WB_RegDest;
  logic [31:0]       WB_WriteData;
  logic [31:0]       WB_PC;
  logic              Advance;
  logic [31:0]       Disp_Data;
  logic [31:0]       Disp_PC;
  logic [4:0]        Disp_RegDest;
  logic              Disp_Valid;
  logic [PTR_W:0]    Count;
  logic              Overflow;
  logic [DROP_W-1:0] Dropped;

  modport master (
    output Freeze, WB_RegWrite, WB_RegDest, WB_WriteData, WB_PC, Advance,
    input  Disp_Data, Disp_PC, Disp_RegDest, Disp_Valid, Count, Overflow, Dropped
  );

  modport slave (
    input  Freeze, WB_RegWrite, WB_RegDest, WB_WriteData, WB_PC, Advance,
    output Disp_Data, Disp_PC, Disp_RegDest, Disp_Valid, Count, Overflow, Dropped
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Captures architectural register writes from WB into a FIFO and presents one
// entry at a time to the display path, stepping on each Advance pulse.
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int DROP_W = 8
) (
  input  logic Clock,
  input  logic Reset,
  wb_trace_buffer_if.slave bus
);

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  entry_t            mem [DEPTH];
  entry_t            disp;
  logic              disp_valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              overflow;
  logic [DROP_W-1:0] dropped;

  logic cap, pop, push, drop, full;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cap  = 1'b0;
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    full = (count == FULL_COUNT);
    cap  = bus.WB_RegWrite && (bus.WB_RegDest != 5'd0) && !bus.Freeze;
    pop  = bus.Advance && (count != '0);
    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    push = cap && (!full || pop);
    drop = cap && full && !pop;
  end

  // NOTE: storage carries no reset; its contents are meaningless until
  // written, and the pointers/count alone define what is valid.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= '{dest: bus.WB_RegDest, pc: bus.WB_PC, data: bus.WB_WriteData};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      disp       <= '0;
      disp_valid <= 1'b0;
      overflow   <= 1'b0;
      dropped    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        disp       <= mem[rd_ptr];
        disp_valid <= 1'b1;
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + DROP_W'(1);
      end
    end
  end

  assign bus.Disp_Data    = disp.data;
  assign bus.Disp_PC      = disp.pc;
  assign bus.Disp_RegDest = disp.dest;
  assign bus.Disp_Valid   = disp_valid;
  assign bus.Count        = count;
  assign bus.Overflow     = overflow;
  assign bus.Dropped      = dropped;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus randomized
// traffic, all compared each cycle against a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic Clock = 1'b0;
  logic Reset;

  wb_trace_buffer_if #(.PTR_W(PTR_W), .DROP_W(DROP_W)) bus ();

  wb_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DROP_W(DROP_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  ent_t q[$];
  ent_t m_disp;
  bit   m_valid;
  bit   m_overflow;
  int   m_dropped;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    q.delete();
    m_disp     = '{dest: 5'd0, pc: 32'd0, data: 32'd0};
    m_valid    = 1'b0;
    m_overflow = 1'b0;
    m_dropped  = 0;
  endtask

  // Applies the rules at one rising edge using the inputs held across it.
  task automatic model_step();
    bit   capture, popping;
    ent_t e;
    if (!Reset) begin
      model_clear();
      return;
    end
    capture = bus.WB_RegWrite && bus.WB_RegDest != 0 && !bus.Freeze;
    popping = bus.Advance && q.size() != 0;
    e = '{dest: bus.WB_RegDest, pc: bus.WB_PC, data: bus.WB_WriteData};
    if (popping) begin
      m_disp  = q.pop_front();
      m_valid = 1'b1;
    end
    if (capture) begin
      if (q.size() < DEPTH) q.push_back(e);
      else begin
        m_overflow = 1'b1;
        if (m_dropped < DROP_MAX) m_dropped++;
      end
    end
  endtask

  task automatic compare_all();
    check("count",    64'(bus.Count),        64'(q.size()));
    check("disp_data", 64'(bus.Disp_Data),   64'(m_disp.data));
    check("disp_pc",  64'(bus.Disp_PC),      64'(m_disp.pc));
    check("disp_dest", 64'(bus.Disp_RegDest), 64'(m_disp.dest));
    check("valid",    64'(bus.Disp_Valid),   64'(m_valid));
    check("overflow", 64'(bus.Overflow),     64'(m_overflow));
    check("dropped",  64'(bus.Dropped),      64'(m_dropped));
  endtask

  task automatic cyc(input logic rst, input logic we, input logic [4:0] d,
                     input logic [31:0] data, input logic [31:0] pc,
                     input logic adv, input logic frz);
    Reset            = rst;
    bus.WB_RegWrite  = we;
    bus.WB_RegDest   = d;
    bus.WB_WriteData = data;
    bus.WB_PC        = pc;
    bus.Advance      = adv;
    bus.Freeze       = frz;
    @(posedge Clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] d, input logic [31:0] data, input logic [31:0] pc);
    cyc(1'b1, 1'b1, d, data, pc, 1'b0, 1'b0);
  endtask

  task automatic adv();
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic fill16();
    for (int i = 1; i <= DEPTH; i++) wr(5'(i), 32'(i), 32'(i * 4));
  endtask

  initial begin
    #2;
    do_reset();
    do_reset();
    check("rst_count", 64'(bus.Count), 64'd0);
    check("rst_valid", 64'(bus.Disp_Valid), 64'd0);
    check("rst_data", 64'(bus.Disp_Data), 64'd0);

    // Basic capture, $0 ignored
    idle();
    wr(5'd8, 32'h11, 32'h00);
    wr(5'd9, 32'h22, 32'h04);
    wr(5'd0, 32'h33, 32'h08);
    check("basic_count", 64'(bus.Count), 64'd2);
    adv();
    check("basic_dest", 64'(bus.Disp_RegDest), 64'd8);
    check("basic_data", 64'(bus.Disp_Data), 64'h11);
    check("basic_pc", 64'(bus.Disp_PC), 64'h0);
    check("basic_valid", 64'(bus.Disp_Valid), 64'd1);
    check("basic_count1", 64'(bus.Count), 64'd1);

    // Fill, overflow, drain in order
    do_reset();
    fill16();
    for (int i = 0; i < 3; i++) wr(5'd20, 32'hDEAD, 32'h100);
    check("full_count", 64'(bus.Count), 64'd16);
    check("full_ovf", 64'(bus.Overflow), 64'd1);
    check("full_drop", 64'(bus.Dropped), 64'd3);
    for (int i = 1; i <= DEPTH; i++) begin
      adv();
      check("drain_data", 64'(bus.Disp_Data), 64'(i));
    end
    check("drain_count", 64'(bus.Count), 64'd0);
    adv();
    check("drain_hold", 64'(bus.Disp_Data), 64'd16);

    // Push and pop together while full; wraps the pointers
    do_reset();
    fill16();
    cyc(1'b1, 1'b1, 5'd30, 32'hAA, 32'h200, 1'b1, 1'b0);
    check("pp_count", 64'(bus.Count), 64'd16);
    check("pp_drop", 64'(bus.Dropped), 64'd0);
    check("pp_disp", 64'(bus.Disp_Data), 64'd1);
    for (int i = 0; i < DEPTH; i++) adv();
    check("pp_last", 64'(bus.Disp_Data), 64'hAA);
    check("pp_last_dest", 64'(bus.Disp_RegDest), 64'd30);

    // No bypass on empty
    do_reset();
    cyc(1'b1, 1'b1, 5'd3, 32'h77, 32'h40, 1'b1, 1'b0);
    check("nb_count", 64'(bus.Count), 64'd1);
    check("nb_valid", 64'(bus.Disp_Valid), 64'd0);
    adv();
    check("nb_show", 64'(bus.Disp_Data), 64'h77);

    // Freeze suppresses capture without counting drops
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 5'(i + 1), 32'(i), 32'd0, 1'b0, 1'b1);
    check("frz_count", 64'(bus.Count), 64'd0);
    check("frz_drop", 64'(bus.Dropped), 64'd0);
    wr(5'd4, 32'h44, 32'h10);
    check("frz_after", 64'(bus.Count), 64'd1);

    // Drop counter saturation, then mid-stream reset
    do_reset();
    fill16();
    for (int i = 0; i < 260; i++) wr(5'd7, 32'(i), 32'h300);
    check("sat_drop", 64'(bus.Dropped), 64'd255);
    adv();
    do_reset();
    check("mid_count", 64'(bus.Count), 64'd0);
    check("mid_valid", 64'(bus.Disp_Valid), 64'd0);
    check("mid_ovf", 64'(bus.Overflow), 64'd0);
    check("mid_drop", 64'(bus.Dropped), 64'd0);
    check("mid_data", 64'(bus.Disp_Data), 64'd0);
    wr(5'd5, 32'h5A, 32'h500);
    adv();
    check("mid_ret_data", 64'(bus.Disp_Data), 64'h5A);
    check("mid_ret_dest", 64'(bus.Disp_RegDest), 64'd5);
    check("mid_ret_pc", 64'(bus.Disp_PC), 64'h500);

    // Randomized traffic with shifting advance rates
    for (int blk = 0; blk < 6; blk++) begin
      int adv_pct;
      adv_pct = (blk % 3 == 0) ? 15 : (blk % 3 == 1) ? 50 : 85;
      for (int i = 0; i < 500; i++) begin
        cyc(($urandom % 300) != 0,
            ($urandom % 100) < 60,
            5'($urandom),
            $urandom,
            $urandom,
            ($urandom % 100) < adv_pct,
            ($urandom % 10) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
